// File: rtl/part4_bist.sv
// part4_bist: BIST driver/checker for the part4 hierarchy test block; define PART4_BIST_FAIL_CAPTURE_EN to latch the first failing vector
module part4_bist #(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [5:0]  LFSR_SEED   = 6'h2D,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [5:0]       stimBus,
    input  logic [4:0]       respBus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] errCount,
    output logic [15:0]      failIdx,
    output logic [5:0]       failStim,
    output logic [4:0]       failResp
);
    localparam logic [5:0]  SEED = (LFSR_SEED == 6'h00) ? 6'h01 : LFSR_SEED;
    localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [1:0] cnt;
    logic [15:0] idx;
    logic [4:0] expResp;
    logic mismatch;
    logic accept;

    // reference counter free-runs regardless of FSM state
    always_ff @(posedge clk) cnt <= reset ? 2'd0 : cnt + 2'd1;

    // golden response for the driven stimulus, plus compare and start qualifiers
    always_comb begin
        expResp  = {stimBus[5] & stimBus[4], ~stimBus[3] & cnt[1], ~stimBus[3] & cnt[0], cnt[0], stimBus[0] & cnt[0]};
        mismatch = (state == RUN) && (respBus != expResp);
        accept   = start && (state != RUN);
    end

    // run control, stimulus generation and saturating error count
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            stimBus  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            errCount <= '0;
            idx      <= '0;
        end else if (accept) begin
            state    <= RUN;
            stimBus  <= SEED;
            busy     <= 1'b1;
            done     <= 1'b0;
            errCount <= '0;
            idx      <= '0;
        end else if (state == RUN) begin
            if (mismatch && errCount != '1) errCount <= errCount + 1'b1;
            if (idx == LAST) begin
                state   <= DONE;
                stimBus <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
            end else begin
                stimBus <= {stimBus[4:0], stimBus[5] ^ stimBus[4]};
                idx     <= idx + 16'd1;
            end
        end
    end

    assign pass = done && (errCount == '0);

`ifdef PART4_BIST_FAIL_CAPTURE_EN
    logic captured;

    // latch the first mismatching vector of a run and hold it until the next start
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            captured <= 1'b0;
            failIdx  <= '0;
            failStim <= '0;
            failResp <= '0;
        end else if (mismatch && !captured) begin
            captured <= 1'b1;
            failIdx  <= idx;
            failStim <= stimBus;
            failResp <= respBus;
        end
    end
`else
    assign failIdx  = '0;
    assign failStim = '0;
    assign failResp = '0;
`endif
endmodule

// File: tb/tb_part4_bist.sv
// tb_part4_bist: randomized self-checking bench for part4_bist against a spec-level model
module tb_part4_bist;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] start = '0;
    logic [4:0] flip = '0;
    logic [1:0] cnt = '0;
    logic [5:0] stim[4];
    logic [4:0] resp[4];
    logic busy[4], done[4], pass[4];
    logic [7:0] errA, errB, errD;
    logic [1:0] errC;
    logic [15:0] fIdx[4];
    logic [5:0] fStim[4];
    logic [4:0] fResp[4];
    logic [5:0] sObs[70];
    logic bObs[70];
    logic [1:0] cObs[70];
    logic [4:0] fPlan[70];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // model of the free-running reference counter
    always @(posedge clk) cnt <= reset ? 2'd0 : cnt + 2'd1;

    function automatic logic [4:0] gold(input logic [5:0] s, input logic [1:0] c);
        return {s[5] & s[4], ~s[3] & c[1], ~s[3] & c[0], c[0], s[0] & c[0]};
    endfunction

    function automatic logic [5:0] nxt(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    assign resp[0] = gold(stim[0], cnt) ^ flip;
    assign resp[1] = gold(stim[1], cnt) | 5'h10;
    assign resp[2] = 5'h00;
    assign resp[3] = gold(stim[3], cnt);

    part4_bist #(.NUM_VECTORS(64), .LFSR_SEED(6'h2D), .ERR_W(8)) uA (
        .clk(clk), .reset(reset), .start(start[0]), .stimBus(stim[0]), .respBus(resp[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .errCount(errA),
        .failIdx(fIdx[0]), .failStim(fStim[0]), .failResp(fResp[0]));
    part4_bist #(.NUM_VECTORS(63), .LFSR_SEED(6'h2D), .ERR_W(8)) uB (
        .clk(clk), .reset(reset), .start(start[1]), .stimBus(stim[1]), .respBus(resp[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .errCount(errB),
        .failIdx(fIdx[1]), .failStim(fStim[1]), .failResp(fResp[1]));
    part4_bist #(.NUM_VECTORS(63), .LFSR_SEED(6'h2D), .ERR_W(2)) uC (
        .clk(clk), .reset(reset), .start(start[2]), .stimBus(stim[2]), .respBus(resp[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .errCount(errC),
        .failIdx(fIdx[2]), .failStim(fStim[2]), .failResp(fResp[2]));
    part4_bist #(.NUM_VECTORS(2), .LFSR_SEED(6'h00), .ERR_W(8)) uD (
        .clk(clk), .reset(reset), .start(start[3]), .stimBus(stim[3]), .respBus(resp[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .errCount(errD),
        .failIdx(fIdx[3]), .failStim(fStim[3]), .failResp(fResp[3]));

    // pulse start on instance k and record n+1 cycles of stimulus/busy/counter
    task automatic applyRun(input int k, input int n, input bit randFlip, input bit randStart);
        @(negedge clk) start[k] = 1'b1;
        @(negedge clk) start[k] = 1'b0;
        for (int i = 0; i <= n; i++) begin
            sObs[i] = stim[k];
            bObs[i] = busy[k];
            cObs[i] = cnt;
            fPlan[i] = (randFlip && i < n && $urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            flip = fPlan[i];
            start[k] = randStart && i < n && $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        flip = '0;
        start[k] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        compared++; if (stim[0] !== 6'h00) begin mismatched++; $display("FAIL reset_stim: got %h want 00", stim[0]); end
        compared++; if (busy[0] !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        compared++; if (done[0] !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done[0]); end
        compared++; if (pass[0] !== 1'b0) begin mismatched++; $display("FAIL reset_pass: got %b want 0", pass[0]); end
        compared++; if (errA !== 8'd0) begin mismatched++; $display("FAIL reset_err: got %0d want 0", errA); end
        compared++; if (fIdx[0] !== 16'd0 || fStim[0] !== 6'd0 || fResp[0] !== 5'd0) begin mismatched++; $display("FAIL reset_capture: got %h/%h/%h want 0", fIdx[0], fStim[0], fResp[0]); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_golden;
        logic [5:0] s = 6'h2D;
        applyRun(0, 64, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            compared++; if (sObs[i] !== s || bObs[i] !== 1'b1) begin mismatched++; $display("FAIL golden_vec%0d: got stim %h busy %b want %h 1", i, sObs[i], bObs[i], s); end
            s = nxt(s);
        end
        compared++; if (bObs[64] !== 1'b0 || sObs[64] !== 6'h00) begin mismatched++; $display("FAIL golden_end: got busy %b stim %h want 0 00", bObs[64], sObs[64]); end
        compared++; if (done[0] !== 1'b1 || pass[0] !== 1'b1) begin mismatched++; $display("FAIL golden_done: got done %b pass %b want 1 1", done[0], pass[0]); end
        compared++; if (errA !== 8'd0) begin mismatched++; $display("FAIL golden_err: got %0d want 0", errA); end
    endtask

    task automatic test_random_errors;
        logic [5:0] s = 6'h2D;
        int errs = 0;
        logic [15:0] eIdx = '0;
        logic [5:0] eStim = '0;
        logic [4:0] eResp = '0;
        bit seen = 0;
        applyRun(0, 64, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            if (fPlan[i] != 0) begin
                errs++;
                if (!seen) begin seen = 1; eIdx = 16'(i); eStim = s; eResp = gold(s, cObs[i]) ^ fPlan[i]; end
            end
            s = nxt(s);
        end
`ifndef PART4_BIST_FAIL_CAPTURE_EN
        eIdx = '0; eStim = '0; eResp = '0;
`endif
        compared++; if (errA !== 8'(errs)) begin mismatched++; $display("FAIL random_err: got %0d want %0d", errA, errs); end
        compared++; if (pass[0] !== (errs == 0)) begin mismatched++; $display("FAIL random_pass: got %b want %b", pass[0], errs == 0); end
        compared++; if (fIdx[0] !== eIdx || fStim[0] !== eStim || fResp[0] !== eResp) begin mismatched++; $display("FAIL random_capture: got %h/%h/%h want %h/%h/%h", fIdx[0], fStim[0], fResp[0], eIdx, eStim, eResp); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] s = 6'h2D;
        int errs = 0;
        applyRun(0, 64, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) begin
            compared++; if (sObs[i] !== s || bObs[i] !== 1'b1) begin mismatched++; $display("FAIL b2b_vec%0d: got stim %h busy %b want %h 1", i, sObs[i], bObs[i], s); end
            if (fPlan[i] != 0) errs++;
            s = nxt(s);
        end
        compared++; if (bObs[64] !== 1'b0 || done[0] !== 1'b1) begin mismatched++; $display("FAIL b2b_end: got busy %b done %b want 0 1", bObs[64], done[0]); end
        compared++; if (errA !== 8'(errs)) begin mismatched++; $display("FAIL b2b_err: got %0d want %0d", errA, errs); end
        applyRun(0, 64, 1'b0, 1'b0);
        compared++; if (errA !== 8'd0 || pass[0] !== 1'b1) begin mismatched++; $display("FAIL b2b_rerun: got err %0d pass %b want 0 1", errA, pass[0]); end
    endtask

    task automatic test_force_bit4;
        logic [5:0] s = 6'h2D;
        int errs = 0;
        logic [15:0] eIdx = '0;
        logic [5:0] eStim = '0;
        logic [4:0] eResp = '0;
        bit seen = 0;
        applyRun(1, 63, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) begin
            if (s[5:4] != 2'b11) begin
                errs++;
                if (!seen) begin seen = 1; eIdx = 16'(i); eStim = s; eResp = gold(s, cObs[i]) | 5'h10; end
            end
            s = nxt(s);
        end
`ifndef PART4_BIST_FAIL_CAPTURE_EN
        eIdx = '0; eStim = '0; eResp = '0;
`endif
        compared++; if (errB !== 8'(errs)) begin mismatched++; $display("FAIL bit4_err: got %0d want %0d", errB, errs); end
        compared++; if (pass[1] !== 1'b0 || done[1] !== 1'b1) begin mismatched++; $display("FAIL bit4_pass: got pass %b done %b want 0 1", pass[1], done[1]); end
        compared++; if (fIdx[1] !== eIdx || fStim[1] !== eStim || fResp[1] !== eResp) begin mismatched++; $display("FAIL bit4_capture: got %h/%h/%h want %h/%h/%h", fIdx[1], fStim[1], fResp[1], eIdx, eStim, eResp); end
    endtask

    task automatic test_saturate;
        logic [5:0] s = 6'h2D;
        int errs = 0;
        applyRun(2, 63, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) begin
            if (gold(s, cObs[i]) != 5'h00) errs++;
            s = nxt(s);
        end
        if (errs > 3) errs = 3;
        compared++; if (errC !== 2'(errs)) begin mismatched++; $display("FAIL sat_err: got %0d want %0d", errC, errs); end
        compared++; if (pass[2] !== 1'b0 || done[2] !== 1'b1) begin mismatched++; $display("FAIL sat_pass: got pass %b done %b want 0 1", pass[2], done[2]); end
    endtask

    task automatic test_seed0;
        applyRun(3, 2, 1'b0, 1'b0);
        compared++; if (sObs[0] !== 6'h01 || bObs[0] !== 1'b1) begin mismatched++; $display("FAIL seed0_v0: got %h busy %b want 01 1", sObs[0], bObs[0]); end
        compared++; if (sObs[1] !== 6'h02 || bObs[1] !== 1'b1) begin mismatched++; $display("FAIL seed0_v1: got %h busy %b want 02 1", sObs[1], bObs[1]); end
        compared++; if (bObs[2] !== 1'b0 || done[3] !== 1'b1 || pass[3] !== 1'b1) begin mismatched++; $display("FAIL seed0_end: got busy %b done %b pass %b want 0 1 1", bObs[2], done[3], pass[3]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        flip = 5'h01;
        repeat (10) @(negedge clk);
        compared++; if (errA !== 8'd10 || busy[0] !== 1'b1) begin mismatched++; $display("FAIL mid_pre: got err %0d busy %b want 10 1", errA, busy[0]); end
        reset = 1'b1;
        flip = '0;
        @(negedge clk);
        compared++; if (busy[0] !== 1'b0 || done[0] !== 1'b0 || stim[0] !== 6'h00 || errA !== 8'd0) begin mismatched++; $display("FAIL mid_reset: got busy %b done %b stim %h err %0d want 0 0 00 0", busy[0], done[0], stim[0], errA); end
        reset = 1'b0;
        applyRun(0, 64, 1'b0, 1'b0);
        compared++; if (sObs[0] !== 6'h2D || sObs[1] !== nxt(6'h2D) || bObs[0] !== 1'b1) begin mismatched++; $display("FAIL mid_replay: got %h %h busy %b want 2d %h 1", sObs[0], sObs[1], bObs[0], nxt(6'h2D)); end
        compared++; if (done[0] !== 1'b1 || pass[0] !== 1'b1) begin mismatched++; $display("FAIL mid_done: got done %b pass %b want 1 1", done[0], pass[0]); end
    endtask

    initial begin
        test_reset;
        test_golden;
        test_random_errors;
        test_back_to_back;
        test_force_bit4;
        test_saturate;
        test_seed0;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
